// File: rtl/spi_txn_sequencer.sv
// Buffered TX/RX front end for an SPI master: queues transmit words,
// launches one transfer at a time and collects received words in order.
module spi_txn_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          m_start_tx,
    output logic [DATA_WIDTH-1:0]         m_tx_data,
    input  logic                          m_busy,
    input  logic                          m_irq,
    input  logic [DATA_WIDTH-1:0]         m_rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_empty, tx_full, rx_empty;

    assign tx_level  = tx_wr_q - tx_rd_q;
    assign rx_level  = rx_wr_q - rx_rd_q;
    assign tx_empty  = (tx_level == '0);
    assign tx_full   = (tx_level == DEPTH);
    assign rx_empty  = (rx_level == '0);
    assign in_ready  = !tx_full;
    assign out_valid = !rx_empty;
    assign out_data  = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
    assign m_tx_data = tx_data_q;
    assign tx_push   = in_valid && !tx_full && !clear;
    assign rx_pop    = out_ready && !rx_empty && !clear;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        m_start_tx = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rx space is reserved here so a later capture cannot overflow
                if (!tx_empty && rx_level < DEPTH && !m_busy) begin
                    state_d   = LAUNCH;
                    tx_data_d = tx_mem_q[tx_rd_q[AW-1:0]];
                end
            end
            LAUNCH: begin
                m_start_tx = 1'b1;
                tx_pop     = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (m_irq) begin
                    rx_push = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            tx_data_d = '0;
            tx_pop    = 1'b0;
            rx_push   = 1'b0;
        end
    end

    always_comb begin
        tx_wr_d = tx_wr_q + {{AW{1'b0}}, tx_push};
        tx_rd_d = tx_rd_q + {{AW{1'b0}}, tx_pop};
        rx_wr_d = rx_wr_q + {{AW{1'b0}}, rx_push};
        rx_rd_d = rx_rd_q + {{AW{1'b0}}, rx_pop};
        if (clear) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
            rx_wr_d = '0;
            rx_rd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q[AW-1:0]] <= in_data;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= m_rx_data;
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with an SPI slave model and
// TX/RX scoreboards fed from the stimulus.
module tb_spi_txn_sequencer;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic out_ready = 1'b0;
    logic m_irq = 1'b0;
    logic [15:0] m_rx_data = '0;
    logic busy_force = 1'b0;
    logic in_ready, out_valid, m_start_tx, m_busy, timeout;
    logic [15:0] out_data, m_tx_data;
    logic [4:0] tx_level, rx_level;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_tmo = 0;
    int start_q[$];
    int tmo_q[$];
    logic [15:0] exp_tx[$];
    logic [15:0] exp_rx[$];
    logic busy_prev = 1'b0;

    bit sl_active = 1'b0;
    bit sl_drop_cur = 1'b0;
    int sl_cnt = 0;
    int sl_delay = 40;
    int sl_drop_n = 0;
    logic [15:0] sl_tx = '0;

    spi_txn_sequencer #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .m_start_tx(m_start_tx), .m_tx_data(m_tx_data),
        .m_busy(m_busy), .m_irq(m_irq), .m_rx_data(m_rx_data),
        .tx_level(tx_level), .rx_level(rx_level), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign m_busy = sl_active | busy_force;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Echoing slave: busy from launch, m_irq after sl_delay cycles.
    always @(posedge clk) begin
        #1;
        m_irq = 1'b0;
        if (sl_active) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                sl_active = 1'b0;
                if (!sl_drop_cur) begin
                    m_irq = 1'b1;
                    m_rx_data = ~sl_tx;
                end
            end
        end else if (m_start_tx) begin
            sl_active = 1'b1;
            sl_tx = m_tx_data;
            if (sl_drop_n > 0) begin
                sl_drop_n--;
                sl_drop_cur = 1'b1;
                sl_cnt = TO + 4;
            end else begin
                sl_drop_cur = 1'b0;
                sl_cnt = sl_delay;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_level_max", tx_level <= 5'd16, 1);
            chk("rx_level_max", rx_level <= 5'd16, 1);
            if (m_start_tx) begin
                n_starts++;
                start_q.push_back(cyc);
                chk("busy_before_start", busy_prev, 0);
                chk("start_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) chk("m_tx_data", m_tx_data, exp_tx.pop_front());
            end
            if (out_valid && out_ready) begin
                chk("out_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) chk("out_data", out_data, exp_rx.pop_front());
            end
            if (timeout) begin
                n_tmo++;
                tmo_q.push_back(cyc);
            end
        end
        busy_prev = m_busy;
    end

    task automatic push(input logic [15:0] w, input bit echo);
        int t = 0;
        in_valid = 1'b1;
        in_data = w;
        while (!in_ready && t < 500) begin
            tick();
            t++;
        end
        chk("push_bound", in_ready, 1);
        tick();
        in_valid = 1'b0;
        exp_tx.push_back(w);
        if (echo) exp_rx.push_back(~w);
    endtask

    task automatic wait_drained(input string tag);
        int t = 0;
        do begin
            tick();
            t++;
        end while (!(tx_level == 0 && rx_level == 0 && !m_busy &&
                     !m_start_tx && exp_rx.size() == 0) && t < 3000);
        chk(tag, t < 3000, 1);
    endtask

    initial begin
        int s0, t0, sa, t;
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_start", m_start_tx, 0);
        chk("rst_tx_data", m_tx_data, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // basic echo with launch latency
        push(16'h1234, 1);
        chk("lvl_n1", tx_level, 1);
        chk("start_n1", m_start_tx, 0);
        tick();
        chk("start_n2", m_start_tx, 1);
        push(16'hBEEF, 1);
        wait_drained("drain_basic");
        chk("basic_starts", n_starts, 2);

        // back-to-back spacing
        sl_delay = 1;
        sa = start_q.size();
        push(16'h0A0A, 1);
        push(16'h0B0B, 1);
        wait_drained("drain_b2b");
        chk("b2b_spacing", start_q[sa + 1] - start_q[sa], 3);

        // TX full while master busy
        sl_delay = 3;
        busy_force = 1'b1;
        s0 = n_starts;
        for (int i = 0; i < 16; i++) push(16'(32'h2000 + i), 1);
        chk("tx_full_ready", in_ready, 0);
        chk("tx_full_level", tx_level, 16);
        in_valid = 1'b1;
        in_data = 16'h2010;
        repeat (3) tick();
        chk("tx_full_hold_ready", in_ready, 0);
        chk("tx_full_hold_level", tx_level, 16);
        chk("tx_full_no_start", n_starts - s0, 0);
        busy_force = 1'b0;
        t = 0;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        tick();
        in_valid = 1'b0;
        exp_tx.push_back(16'h2010);
        exp_rx.push_back(~16'h2010);
        chk("launch_before_17th", n_starts - s0 >= 1, 1);
        wait_drained("drain_full");
        chk("full_starts", n_starts - s0, 17);

        // RX full backpressure
        sl_delay = 2;
        out_ready = 1'b0;
        s0 = n_starts;
        for (int i = 0; i < 17; i++) push(16'(32'h3000 + i), 1);
        t = 0;
        while (rx_level != 16 && t < 500) begin
            tick();
            t++;
        end
        repeat (10) tick();
        chk("rx_full_level", rx_level, 16);
        chk("rx_full_starts", n_starts - s0, 16);
        chk("rx_full_tx_held", tx_level, 1);
        chk("rx_full_in_ready", in_ready, 1);
        chk("rx_full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drained("drain_rx_full");
        chk("rx_full_total", n_starts - s0, 17);

        // timeout then next word
        sl_delay = 3;
        sl_drop_n = 1;
        sa = start_q.size();
        t0 = n_tmo;
        push(16'hA5A5, 0);
        push(16'h5A5A, 1);
        wait_drained("drain_tmo");
        chk("tmo_count", n_tmo - t0, 1);
        if (tmo_q.size() > 0)
            chk("tmo_cycle", tmo_q[tmo_q.size() - 1] - start_q[sa], TO);
        chk("tmo_next_launch", start_q.size() - sa, 2);

        // m_irq on the expiry cycle
        sl_delay = TO;
        t0 = n_tmo;
        push(16'hC3C3, 1);
        wait_drained("drain_tie");
        chk("irq_wins", n_tmo - t0, 0);

        // clear mid-transfer
        sl_delay = 30;
        s0 = n_starts;
        for (int i = 0; i < 4; i++) push(16'(32'h6000 + i), 0);
        chk("pre_clear_tx", tx_level, 3);
        chk("pre_clear_starts", n_starts - s0, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_tx.delete();
        chk("clr_tx_level", tx_level, 0);
        chk("clr_rx_level", rx_level, 0);
        chk("clr_tx_data", m_tx_data, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        push(16'hD00D, 1);
        repeat (5) tick();
        chk("clr_wait_busy", n_starts - s0, 1);
        wait_drained("drain_clear");
        chk("clr_relaunch", n_starts - s0, 2);

        // reset mid-transfer
        sl_delay = 20;
        s0 = n_starts;
        push(16'hE1E1, 0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstm_tx_data", m_tx_data, 0);
        chk("rstm_tx_level", tx_level, 0);
        repeat (30) tick();
        chk("rstm_rx_level", rx_level, 0);
        chk("rstm_starts", n_starts - s0, 1);

        chk("exp_tx_empty", exp_tx.size(), 0);
        chk("exp_rx_empty", exp_rx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Buffered transaction front end that sits directly upstream of the SPI master. It accepts transmit words from the system over a valid/ready stream and queues them in a TX FIFO. It launches one SPI transfer at a time on the master's start/busy/irq interface, then captures each received word into an RX FIFO. The RX FIFO is presented back to the system as a valid/ready stream.

## Interface
- DATA_WIDTH, 16, word width; equals the SPI master's data width
- FIFO_DEPTH, 16, entries per FIFO; power of two, >= 2
- TIMEOUT_CYCLES, 4096, clk cycles allowed from launch to m_irq before abort; >= 2

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush of both FIFOs and sequencer
- in_valid  in  1  TX word valid
- in_ready  out  1  TX FIFO can accept (= not full)
- in_data  in  DATA_WIDTH  word to transmit
- out_valid  out  1  RX FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_WIDTH  oldest received word (show-ahead)
- m_start_tx  out  1  one-cycle launch pulse to SPI master
- m_tx_data  out  DATA_WIDTH  word for SPI master, registered
- m_busy  in  1  SPI master busy
- m_irq  in  1  SPI master completion pulse
- m_rx_data  in  DATA_WIDTH  SPI master received word, valid while m_irq=1
- tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
- timeout  out  1  one-cycle pulse when a transfer is aborted

## Operation
- **Reset (rst_n=0 at a clk edge):**
  - FIFOs empty, state IDLE.
  - in_ready=1, out_valid=0, out_data=0, m_start_tx=0, m_tx_data=0.
  - tx_level=0, rx_level=0, timeout=0.
- **FIFOs:**
  - Circular buffers with read/write pointers one bit wider than the index; wrap at FIFO_DEPTH.
  - Push when valid&&ready. in_ready depends only on full, never on out_ready or pops.
  - A push while full is dropped (it cannot handshake).
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
- **IDLE:**
  - Go to LAUNCH when all hold: TX non-empty, rx_level < FIFO_DEPTH, m_busy=0.
  - The rx_level check reserves space, so a capture never overflows.
- **LAUNCH (1 cycle):**
  - m_start_tx=1; m_tx_data is loaded with the TX head at entry.
  - TX FIFO is popped; timeout counter set to 0.
  - Next state is WAIT_DONE.
- **WAIT_DONE:**
  - m_tx_data is held. The counter increments every cycle.
  - On m_irq=1: write m_rx_data into RX FIFO, go to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 without m_irq: pulse timeout, push nothing, go to IDLE.
  - If m_irq and the timeout limit land on the same cycle, m_irq wins (capture, no timeout pulse).
- **m_irq outside WAIT_DONE:** ignored.
- **clear=1:**
  - Same cycle effect as reset, except the pending-busy rule still applies.
  - The next launch waits for m_busy=0.
  - clear has priority over every push, pop and capture in that cycle.
- **Ordering:** RX words leave in the same order as their TX words entered. Timed-out transfers leave no RX entry.

## Timing
- **Empty TX, state IDLE, m_busy=0:**
  - in handshake at cycle N.
  - tx_level=1 at N+1.
  - m_start_tx=1 at N+2.
- **m_start_tx:** high for exactly one cycle per transfer, never while m_busy=1 was sampled in the preceding IDLE cycle.
- **RX capture:** m_irq at cycle C gives rx_level increment and out_valid=1 at C+1 (from empty).
- **out_data:** equals the RX head combinationally from pointers. A pop at C+1 exposes the next word at C+2.
- **Back-to-back:** minimum spacing between two m_start_tx pulses is 3 cycles (LAUNCH, WAIT_DONE with m_irq, IDLE).
- **timeout:** asserted for exactly one cycle, at the cycle WAIT_DONE exits without m_irq.
- **Reset mid-transfer:**
  - Takes effect at the next edge.
  - Later m_irq is ignored; the next launch waits for m_busy=0.

## Test plan
- Push 0x1234, 0xBEEF; a slave model echoes ~tx after 40 cycles → m_tx_data 0x1234 then 0xBEEF, each with a single m_start_tx; out stream yields 0xEDCB then 0x4110.
- Push 17 words with FIFO_DEPTH=16 while m_busy=1 → in_ready=0 after 16, 17th accepted only after first launch; tx_level never exceeds 16.
- Hold out_ready=0 across 16 completed transfers → rx_level=16, no 17th m_start_tx until one pop, all data intact in order.
- Never assert m_irq, TIMEOUT_CYCLES=8 → timeout pulse 8 cycles after LAUNCH, rx_level stays 0, next queued word launches.
- m_irq on the same cycle as timeout expiry → word captured, timeout stays 0.
- clear (or rst_n=0) during WAIT_DONE with 3 words queued → levels 0 next cycle, late m_irq ignored, no m_start_tx until a new push and m_busy=0.
